// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_word_t;

   localparam reg_idx_t ZERO_REG = 5'd0;

   // Named MIPS register indices
   localparam reg_idx_t T0 = 5'd8;
   localparam reg_idx_t T1 = 5'd9;
   localparam reg_idx_t T2 = 5'd10;
   localparam reg_idx_t T3 = 5'd11;
   localparam reg_idx_t S0 = 5'd16;
   localparam reg_idx_t S1 = 5'd17;
   localparam reg_idx_t S2 = 5'd18;
   localparam reg_idx_t S3 = 5'd19;
   localparam reg_idx_t S4 = 5'd20;
   localparam reg_idx_t S5 = 5'd21;
   localparam reg_idx_t S6 = 5'd22;
   localparam reg_idx_t S7 = 5'd23;
   localparam reg_idx_t SP = 5'd29;
   localparam reg_idx_t RA = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, $zero masking and optional write-through.
// Macro REGFILE_BYPASS_EN enables forwarding of the in-flight write data.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DW  = 32,
   parameter int unsigned AW  = 5,
   parameter int unsigned NR  = 32
) (
   input  logic [AW-1:0] i_sel,
   input  logic [DW-1:0] i_regs [NR],
   input  logic          i_wen,
   input  logic [AW-1:0] i_wsel,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_data
);

   logic w_is_zero;

   assign w_is_zero = (i_sel == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
   logic w_fwd;

   // rd=0 is never forwarded; the zero mask below wins anyway
   assign w_fwd = i_wen && (i_wsel == i_sel) && !w_is_zero;
`else
   logic unused_bypass;

   assign unused_bypass = ^{i_wen, i_wsel, i_wdata};
`endif

   // Select stored word, optionally override with write data, force $zero to 0
   always_comb begin
      o_data = i_regs[i_sel];
`ifdef REGFILE_BYPASS_EN
      if (w_fwd) begin
         o_data = i_wdata;
      end
`endif
      if (w_is_zero) begin
         o_data = '0;
      end
   end

endmodule

// File: rtl/register_file.sv
// MIPS 32 x 32-bit register file: two combinational reads, one synchronous write.
// Storage array is named `register` for hierarchical access by the CPU bench.
// Macro REGFILE_BYPASS_EN enables write-through forwarding on both read ports.
module register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] writedata,
   input  logic              regwrite,
   output logic [DATA_W-1:0] rsdata,
   output logic [DATA_W-1:0] rtdata
);

   logic [DATA_W-1:0] register [0:NUM_REGS-1];
   logic [DATA_W-1:0] w_regs   [NUM_REGS];
   logic              w_wr_en;

   // Writes to $zero are dropped so entry 0 stays at its reset value
   assign w_wr_en = regwrite && (rd != ADDR_W'(ZERO_REG));

   // Async clear of every entry; otherwise a single synchronous write to rd
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            register[i] <= '0;
         end
      end else if (w_wr_en) begin
         register[rd] <= writedata;
      end
   end

   // Repack storage into a zero-based array for the read-port sub-modules
   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         w_regs[i] = register[i];
      end
   end

   regfile_read_port #(
      .DW (DATA_W),
      .AW (ADDR_W),
      .NR (NUM_REGS)
   ) u_rs_port (
      .i_sel   (rs),
      .i_regs  (w_regs),
      .i_wen   (regwrite),
      .i_wsel  (rd),
      .i_wdata (writedata),
      .o_data  (rsdata)
   );

   regfile_read_port #(
      .DW (DATA_W),
      .AW (ADDR_W),
      .NR (NUM_REGS)
   ) u_rt_port (
      .i_sel   (rt),
      .i_regs  (w_regs),
      .i_wen   (regwrite),
      .i_wsel  (rd),
      .i_wdata (writedata),
      .o_data  (rtdata)
   );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps then randomized traffic
// checked against an array-based reference model. Honours REGFILE_BYPASS_EN.
module tb_register_file;
   import regfile_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs, rt, rd;
   logic [31:0] writedata;
   logic        regwrite;
   logic [31:0] rsdata, rtdata;

   logic [31:0] model [32];
   int          checks;
   int          errors;

   register_file #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .writedata (writedata),
      .regwrite  (regwrite),
      .rsdata    (rsdata),
      .rtdata    (rtdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Value a read port should present right now, from the architectural rules
   function automatic logic [31:0] exp_read(input logic [4:0] sel);
      if (sel == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (regwrite && rd != 5'd0 && rd == sel) return writedata;
`endif
      return model[sel];
   endfunction

   function automatic logic [31:0] pre_edge(input logic [4:0] sel, input logic [31:0] old_v,
                                            input logic [31:0] new_v);
      if (sel == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      return new_v;
`else
      return old_v;
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   // One rising edge; model applies the write, then sample 1 time unit later
   task automatic tick();
      @(posedge clk);
      if (rst_n && regwrite && rd != 5'd0) model[rd] = writedata;
      #1;
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 32; i++) check(tag, dut.register[i], model[i]);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      rs        = '0;
      rt        = '0;
      rd        = '0;
      writedata = '0;
      regwrite  = 1'b0;
      clear_model();

      // Reset state
      #3;
      rs = S0;
      rt = T0;
      #1;
      check_all_regs("reset_entry");
      check("reset_rsdata", rsdata, 32'd0);
      check("reset_rtdata", rtdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic write/read
      regwrite = 1'b1; rd = S0; writedata = 32'h0000_1234;
      tick();
      regwrite = 1'b0; rs = S0; rt = S1;
      #1;
      check("basic_reg16", dut.register[16], 32'h0000_1234);
      check("basic_rsdata", rsdata, 32'h0000_1234);
      check("basic_rtdata", rtdata, 32'd0);

      // $zero protection
      regwrite = 1'b1; rd = ZERO_REG; writedata = 32'hFFFF_FFFF;
      tick();
      regwrite = 1'b0; rs = ZERO_REG;
      #1;
      check("zero_reg0", dut.register[0], 32'd0);
      check("zero_rsdata", rsdata, 32'd0);

      // Write-enable low
      regwrite = 1'b0; rd = T1; writedata = 32'hDEAD_BEEF;
      tick();
      check("wen_low_reg9", dut.register[9], 32'd0);
      rt = T1;
      #1;
      check("wen_low_rtdata", rtdata, 32'd0);

      // Dual read with same-cycle write to the same register
      regwrite = 1'b1; rd = T2; writedata = 32'hAAAA_5555;
      tick();
      rs = T2; rt = T2; rd = T2; writedata = 32'h1111_2222; regwrite = 1'b1;
      #1;
      check("rdw_pre_rs", rsdata, pre_edge(T2, 32'hAAAA_5555, 32'h1111_2222));
      check("rdw_pre_rt", rtdata, pre_edge(T2, 32'hAAAA_5555, 32'h1111_2222));
      tick();
      check("rdw_post_rs", rsdata, 32'h1111_2222);
      check("rdw_post_rt", rtdata, 32'h1111_2222);
      regwrite = 1'b0;

      // Async reset mid-operation, then a write while held in reset
      regwrite = 1'b1; rd = S5; writedata = 32'h0000_00FF;
      tick();
      regwrite = 1'b0;
      #1;
      check("mid_pre_reg21", dut.register[21], 32'h0000_00FF);
      rst_n = 1'b0;
      clear_model();
      #1;
      check("mid_reset_reg21", dut.register[21], 32'd0);
      check_all_regs("mid_reset_entry");
      regwrite = 1'b1; rd = S5; writedata = 32'h5A5A_5A5A;
      tick();
      check("reset_hold_reg21", dut.register[21], 32'd0);
      regwrite = 1'b0;
      #2;
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rd        = 5'($urandom_range(0, 31));
         rs        = 5'($urandom_range(0, 31));
         rt        = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) rs = rd;
         if ($urandom_range(0, 3) == 0) rt = rd;
         if ($urandom_range(0, 7) == 0) rt = rs;
         writedata = $urandom;
         regwrite  = ($urandom_range(0, 9) < 7);
         #1;
         check("rand_pre_rs", rsdata, exp_read(rs));
         check("rand_pre_rt", rtdata, exp_read(rt));
         tick();
         regwrite = 1'b0;
         #1;
         check("rand_post_rs", rsdata, exp_read(rs));
         check("rand_post_rt", rtdata, exp_read(rt));
         check("rand_entry", dut.register[rd], model[rd]);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            clear_model();
            #1;
            check("rand_reset_rs", rsdata, 32'd0);
            check("rand_reset_rt", rtdata, 32'd0);
            check("rand_reset_entry", dut.register[rd], 32'd0);
            #1;
            rst_n = 1'b1;
         end
      end

      check_all_regs("final_entry");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
